// File: rtl/cmd_rx_sequencer_if.sv
// Handshake bundle between the SD command layer and the CMD-line response receive sequencer.
interface cmd_rx_sequencer_if;
  logic       start;
  logic       long_resp;
  logic       abort;
  logic       cmd_in;
  logic       deser_enable;
  logic       deser_reset;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       end_bit_err;
  logic [7:0] bit_count;

  modport master (
    output start, long_resp, abort, cmd_in,
    input  deser_enable, deser_reset, busy, done, timeout, end_bit_err, bit_count
  );

  modport slave (
    input  start, long_resp, abort, cmd_in,
    output deser_enable, deser_reset, busy, done, timeout, end_bit_err, bit_count
  );
endinterface

// File: rtl/cmd_rx_sequencer.sv
// CMD-line response receive controller: waits for a start bit, frames one 48/136-bit
// response for the deserializer and checks the end bit.
module cmd_rx_sequencer #(
  parameter int SHORT_BITS = 48,
  parameter int LONG_BITS  = 136,
  parameter int TIMEOUT    = 64
) (
  input  logic               sd_clock,
  input  logic               reset,
  cmd_rx_sequencer_if.slave  rx
);

  localparam int             CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]     LEN_SHORT = 8'(SHORT_BITS);
  localparam logic [7:0]     LEN_LONG  = 8'(LONG_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [7:0]      r_bit_count;
  logic [7:0]      r_frame_len;
  logic            r_end_bit_err;
  logic            r_deser_reset;
  logic            r_timeout;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_wait_cnt_nxt;
  logic [7:0]      w_bit_count_nxt;
  logic [7:0]      w_frame_len_nxt;
  logic            w_end_bit_err_nxt;
  logic            w_deser_reset_nxt;
  logic            w_timeout_nxt;
  logic            w_deser_enable;

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_bit_count   <= '0;
      r_frame_len   <= '0;
      r_end_bit_err <= 1'b0;
      r_deser_reset <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_bit_count   <= w_bit_count_nxt;
      r_frame_len   <= w_frame_len_nxt;
      r_end_bit_err <= w_end_bit_err_nxt;
      r_deser_reset <= w_deser_reset_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  // r_deser_reset is high exactly in the first WAIT_START cycle, so it doubles as the
  // guard that keeps a low CMD line in that cycle from being taken as the start bit.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_bit_count_nxt   = r_bit_count;
    w_frame_len_nxt   = r_frame_len;
    w_end_bit_err_nxt = r_end_bit_err;
    w_deser_reset_nxt = 1'b0;
    w_timeout_nxt     = 1'b0;
    w_deser_enable    = 1'b0;

    if (rx.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx.start) begin
            w_state_nxt       = S_WAIT_START;
            w_frame_len_nxt   = rx.long_resp ? LEN_LONG : LEN_SHORT;
            w_wait_cnt_nxt    = '0;
            w_bit_count_nxt   = '0;
            w_end_bit_err_nxt = 1'b0;
            w_deser_reset_nxt = 1'b1;
          end
        end
        S_WAIT_START: begin
          w_wait_cnt_nxt = r_wait_cnt + CW'(1);
          if (!r_deser_reset && !rx.cmd_in) begin
            w_deser_enable  = 1'b1;
            w_state_nxt     = S_RECEIVE;
            w_bit_count_nxt = 8'd1;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_nxt = 1'b1;
          end
        end
        S_RECEIVE: begin
          w_deser_enable = 1'b1;
          if (r_bit_count == r_frame_len - 8'd1) begin
            w_bit_count_nxt   = r_frame_len;
            w_end_bit_err_nxt = ~rx.cmd_in;
            w_state_nxt       = S_DONE;
          end else begin
            w_bit_count_nxt = r_bit_count + 8'd1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign rx.deser_enable = w_deser_enable;
  assign rx.deser_reset  = r_deser_reset;
  assign rx.busy         = (r_state != S_IDLE);
  assign rx.done         = (r_state == S_DONE);
  assign rx.timeout      = r_timeout;
  assign rx.end_bit_err  = r_end_bit_err;
  assign rx.bit_count    = r_bit_count;

endmodule

// File: tb/tb_cmd_rx_sequencer.sv
// Randomized transaction-level bench for cmd_rx_sequencer; expectations come from frame arithmetic.
module tb_cmd_rx_sequencer;

  localparam int T  = 64;
  localparam int SB = 48;
  localparam int LB = 136;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_rx_sequencer_if rx();

  cmd_rx_sequencer #(
    .SHORT_BITS (SB),
    .LONG_BITS  (LB),
    .TIMEOUT    (T)
  ) dut (
    .sd_clock (clk),
    .reset    (rst_n),
    .rx       (rx)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  // edge counter: during the cycle following edge e, cyc_n == e
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int m_en = 0, m_done = 0, m_done_at = -1, m_to = 0, m_to_at = -1;
  int m_dres = 0, m_dres_at = -1, m_busy = 0, m_viol = 0;

  always @(negedge clk) begin
    if (rx.deser_enable) m_en <= m_en + 1;
    if (rx.done) begin
      m_done    <= m_done + 1;
      m_done_at <= cyc_n;
    end
    if (rx.timeout) begin
      m_to    <= m_to + 1;
      m_to_at <= cyc_n;
    end
    if (rx.deser_reset) begin
      m_dres    <= m_dres + 1;
      m_dres_at <= cyc_n;
    end
    if (rx.busy) m_busy <= m_busy + 1;
    if ((rx.done && rx.deser_enable) || (rx.timeout && rx.deser_enable) || (rx.done && rx.timeout))
      m_viol <= m_viol + 1;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(rx.busy), 0);
    chk({tag, "_en"},   int'(rx.deser_enable), 0);
    chk({tag, "_dres"}, int'(rx.deser_reset), 0);
    chk({tag, "_done"}, int'(rx.done), 0);
    chk({tag, "_to"},   int'(rx.timeout), 0);
    chk({tag, "_err"},  int'(rx.end_bit_err), 0);
    chk({tag, "_bc"},   int'(rx.bit_count), 0);
  endtask

  // One request: guard = CMD value in the ignored first cycle, dly = extra idle-high cycles
  // before the start bit (dly >= T-1 means no start bit at all), abt = bit count at abort (0 = none).
  task automatic run_txn(input string tag, input bit lng, input int dly, input bit endb,
                         input int abt, input bit guard);
    int L, k, s, idx;
    bit to_case;
    logic cq[$];
    logic aq[$];
    int b_en, b_done, b_to, b_dres, b_busy, b_viol;
    int e_en, e_done, e_to, e_bc, e_err, e_busy;

    L       = lng ? LB : SB;
    to_case = (dly >= T - 1);
    cq.push_back(guard); aq.push_back(1'b0);
    if (to_case) begin
      while (cq.size() < T) begin cq.push_back(1'b1); aq.push_back(1'b0); end
    end else begin
      for (int d = 0; d < dly; d++) begin cq.push_back(1'b1); aq.push_back(1'b0); end
      cq.push_back(1'b0); aq.push_back(1'b0);
      for (int j = 2; j < L; j++) begin cq.push_back(1'($urandom % 2)); aq.push_back(1'b0); end
      cq.push_back(endb); aq.push_back(1'b0);
      if (abt > 0) begin
        idx = dly + 1 + abt;
        aq[idx] = 1'b1;
        while (cq.size() > idx + 1) begin void'(cq.pop_back()); void'(aq.pop_back()); end
      end
    end
    if (to_case || abt == 0) begin cq.push_back(1'b1); aq.push_back(1'b0); end

    b_en = m_en; b_done = m_done; b_to = m_to; b_dres = m_dres; b_busy = m_busy; b_viol = m_viol;

    rx.start = 1'b1; rx.long_resp = lng; rx.cmd_in = 1'b1; rx.abort = 1'b0;
    @(posedge clk); #1;
    k = cyc_n;
    rx.start = 1'b0;
    rx.long_resp = 1'($urandom % 2);
    for (int i = 0; i < cq.size(); i++) begin
      rx.cmd_in = cq[i];
      rx.abort  = aq[i];
      @(posedge clk); #1;
    end
    rx.cmd_in = 1'b1;
    rx.abort  = 1'b0;

    s = k + 2 + dly;
    if (to_case) begin
      e_en = 0; e_done = 0; e_to = 1; e_bc = 0; e_err = 0; e_busy = T;
    end else if (abt > 0) begin
      e_en = abt; e_done = 0; e_to = 0; e_bc = abt; e_err = 0; e_busy = dly + 2 + abt;
    end else begin
      e_en = L; e_done = 1; e_to = 0; e_bc = L; e_err = endb ? 0 : 1; e_busy = dly + L + 2;
    end

    chk({tag, "_enable_cycles"}, m_en - b_en, e_en);
    chk({tag, "_done_pulses"},   m_done - b_done, e_done);
    if (e_done == 1) chk({tag, "_done_cycle"}, m_done_at, s + L - 1);
    chk({tag, "_timeout_pulses"}, m_to - b_to, e_to);
    if (e_to == 1) chk({tag, "_timeout_cycle"}, m_to_at, k + T);
    chk({tag, "_bit_count"},   int'(rx.bit_count), e_bc);
    chk({tag, "_end_bit_err"}, int'(rx.end_bit_err), e_err);
    chk({tag, "_dres_cycles"}, m_dres - b_dres, 1);
    chk({tag, "_dres_cycle"},  m_dres_at, k);
    chk({tag, "_busy_cycles"}, m_busy - b_busy, e_busy);
    chk({tag, "_exclusive"},   m_viol - b_viol, 0);
  endtask

  initial begin
    int dly, abt, r;
    bit lng;
    rx.start = 1'b0; rx.long_resp = 1'b0; rx.abort = 1'b0; rx.cmd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_txn("short_ok",      1'b0, 4,     1'b1, 0,  1'b1);
    run_txn("long_bad_end",  1'b1, 7,     1'b0, 0,  1'b1);
    run_txn("timeout",       1'b0, T - 1, 1'b1, 0,  1'b1);
    run_txn("last_window",   1'b0, T - 2, 1'b1, 0,  1'b1);
    run_txn("guard_to",      1'b0, T - 1, 1'b1, 0,  1'b0);
    run_txn("guard_rx",      1'b1, 3,     1'b1, 0,  1'b0);
    run_txn("abort20",       1'b0, 2,     1'b1, 20, 1'b1);
    run_txn("after_abort",   1'b0, 0,     1'b1, 0,  1'b1);
    run_txn("abort_last",    1'b1, 1,     1'b1, LB - 1, 1'b1);

    // asynchronous reset in the middle of a frame
    rx.start = 1'b1; rx.long_resp = 1'b0;
    @(posedge clk); #1;
    rx.start = 1'b0;
    rx.cmd_in = 1'b1;
    @(posedge clk); #1;
    rx.cmd_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rx.cmd_in = 1'($urandom % 2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rx.cmd_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn("after_rst", 1'b0, 1, 1'b1, 0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      lng = 1'($urandom % 2);
      r   = int'($urandom_range(0, 9));
      if (r == 0)      dly = T - 2;
      else if (r == 1) dly = T - 1;
      else             dly = int'($urandom_range(0, 20));
      abt = 0;
      if (dly < T - 1 && $urandom_range(0, 4) == 0)
        abt = int'($urandom_range(1, (lng ? LB : SB) - 1));
      run_txn($sformatf("rnd%0d", n), lng, dly, 1'($urandom % 2), abt, 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
